// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller (SR, Cause, EPC, PRId) beside the M stage.
// Optional BadVAddr register (addr 8) and bad_addr input are enabled by defining CP0_BADVADDR_EN.
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID_VAL   = 32'h2023_0007,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic        eret_m,
    input  logic [5:0]  hw_int,
`ifdef CP0_BADVADDR_EN
    input  logic [31:0] bad_addr,
`endif
    output logic        req,
    output logic [31:0] epc_out,
    output logic [31:0] handler_pc
);

    localparam logic [4:0] ADDR_BADVADDR = 5'd8;
    localparam logic [4:0] ADDR_SR       = 5'd12;
    localparam logic [4:0] ADDR_CAUSE    = 5'd13;
    localparam logic [4:0] ADDR_EPC      = 5'd14;
    localparam logic [4:0] ADDR_PRID     = 5'd15;

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:2] epc;

    logic        int_pend;
    logic        exc_pend;
    logic [31:0] epc_next;
    logic [31:0] sr_word;
    logic [31:0] cause_word;
    logic        unused_bits;

    assign int_pend = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
    assign exc_pend = (exc_code_in != 5'd0) & ~sr_exl;
    assign req      = (int_pend | exc_pend) & ~reset;

    // A delay-slot victim resumes at its branch, one word earlier.
    assign epc_next = bd_in ? (vpc - 32'd4) : vpc;

    assign sr_word    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
    assign cause_word = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};
    assign epc_out    = {epc, 2'b00};
    assign handler_pc = HANDLER_PC;

    // Word alignment drops the low address bits on every EPC load.
    assign unused_bits = ^{cp0_wdata[1:0], epc_next[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_im     <= '0;
            sr_exl    <= 1'b0;
            sr_ie     <= 1'b0;
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
            epc       <= '0;
        end else begin
            cause_ip <= hw_int;
            if (req) begin
                // The M instruction is the victim: its own mtc0/eret is discarded.
                sr_exl    <= 1'b1;
                cause_exc <= int_pend ? 5'd0 : exc_code_in;
                cause_bd  <= bd_in;
                epc       <= epc_next[31:2];
            end else begin
                if (we && cp0_addr == ADDR_SR) begin
                    sr_im  <= cp0_wdata[15:10];
                    sr_exl <= cp0_wdata[1];
                    sr_ie  <= cp0_wdata[0];
                end
                if (we && cp0_addr == ADDR_EPC)
                    epc <= cp0_wdata[31:2];
                // NOTE: placed after the mtc0 write so eret's EXL clear wins on the same edge.
                if (eret_m)
                    sr_exl <= 1'b0;
            end
        end
    end

`ifdef CP0_BADVADDR_EN
    logic [31:0] badvaddr;

    always_ff @(posedge clk) begin
        if (reset)
            badvaddr <= '0;
        else if (req && !int_pend && (exc_code_in == 5'd4 || exc_code_in == 5'd5))
            badvaddr <= bad_addr;
    end
`endif

    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
`ifdef CP0_BADVADDR_EN
            ADDR_BADVADDR: cp0_rdata = badvaddr;
`else
            ADDR_BADVADDR: cp0_rdata = '0;
`endif
            ADDR_SR:       cp0_rdata = sr_word;
            ADDR_CAUSE:    cp0_rdata = cause_word;
            ADDR_EPC:      cp0_rdata = {epc, 2'b00};
            ADDR_PRID:     cp0_rdata = PRID_VAL;
            default:       cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Directed scoreboard bench for cp0_exc_ctrl; expectations are queued when stimulus is
// driven and popped when the DUT output is sampled on the low clock phase.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic [31:0] cp0_rdata;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic        eret_m;
    logic [5:0]  hw_int;
    logic        req;
    logic [31:0] epc_out;
    logic [31:0] handler_pc;
`ifdef CP0_BADVADDR_EN
    logic [31:0] bad_addr;
`endif

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cp0_exc_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .we         (we),
        .cp0_addr   (cp0_addr),
        .cp0_wdata  (cp0_wdata),
        .cp0_rdata  (cp0_rdata),
        .vpc        (vpc),
        .bd_in      (bd_in),
        .exc_code_in(exc_code_in),
        .eret_m     (eret_m),
        .hw_int     (hw_int),
`ifdef CP0_BADVADDR_EN
        .bad_addr   (bad_addr),
`endif
        .req        (req),
        .epc_out    (epc_out),
        .handler_pc (handler_pc)
    );

    function automatic logic [31:0] cause_of(logic bd, logic [5:0] ip, logic [4:0] code);
        return {bd, 15'b0, ip, 3'b0, code, 2'b0};
    endfunction

    task automatic push(string tag, logic [31:0] exp);
        sb_item_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic compare(logic [31:0] obs);
        sb_item_t it;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: observed %h required a queued expectation", obs);
        end else begin
            it = sb_q.pop_front();
            assert (obs === it.exp) else begin
                errors++;
                $error("FAIL %s: observed %h expected %h", it.tag, obs, it.exp);
            end
        end
    endtask

    task automatic rd(logic [4:0] addr);
        cp0_addr = addr;
        #1;
        compare(cp0_rdata);
    endtask

    task automatic chk_req();
        #1;
        compare({31'b0, req});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        we          = 1'b0;
        cp0_addr    = 5'd0;
        cp0_wdata   = '0;
        vpc         = '0;
        bd_in       = 1'b0;
        exc_code_in = '0;
        eret_m      = 1'b0;
        hw_int      = '0;
`ifdef CP0_BADVADDR_EN
        bad_addr    = '0;
`endif
    endtask

    task automatic mtc0(logic [4:0] addr, logic [31:0] data);
        we        = 1'b1;
        cp0_addr  = addr;
        cp0_wdata = data;
        tick();
        idle();
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick();

        // Reset gating: causes present while reset is high must not raise req.
        hw_int = 6'h3F;
        exc_code_in = 5'd12;
        push("req_in_reset", 32'd0);
        chk_req();
        tick();
        idle();
        reset = 1'b0;
        push("sr_reset", 32'd0);          rd(5'd12);
        push("cause_reset", 32'd0);       rd(5'd13);
        push("epc_reset", 32'd0);         rd(5'd14);
        push("prid", 32'h2023_0007);      rd(5'd15);
        push("addr8_reset", 32'd0);       rd(5'd8);
        push("unmapped", 32'd0);          rd(5'd3);
        push("handler_pc", 32'h0000_4180); #1 compare(handler_pc);
        push("epc_out_reset", 32'd0);     compare(epc_out);

        // Interrupt path.
        mtc0(5'd12, 32'h0000_FC01);
        push("sr_write", 32'h0000_FC01);  rd(5'd12);
        hw_int = 6'b000100;
        vpc = 32'h0000_1000;
        push("int_req", 32'd1);           chk_req();
        tick();
        push("int_no_req_exl", 32'd0);    chk_req();
        push("int_cause", 32'h0000_1000); rd(5'd13);
        push("int_sr_exl", 32'h0000_FC03); rd(5'd12);
        push("int_epc", 32'h0000_1000);   rd(5'd14);
        push("int_epc_out", 32'h0000_1000); compare(epc_out);
        idle();

        // eret, then disable IE and take an overflow exception.
        eret_m = 1'b1;
        tick();
        idle();
        push("eret_sr", 32'h0000_FC01);   rd(5'd12);
        mtc0(5'd12, 32'h0000_FC00);
        exc_code_in = 5'd12;
        vpc = 32'h0000_3010;
        push("ov_req", 32'd1);            chk_req();
        tick();
        idle();
        push("ov_epc", 32'h0000_3010);    rd(5'd14);
        push("ov_cause", cause_of(1'b0, 6'd0, 5'd12)); rd(5'd13);
        push("ov_sr", 32'h0000_FC02);     rd(5'd12);

        // Same exception in a delay slot.
        eret_m = 1'b1;
        tick();
        idle();
        exc_code_in = 5'd12;
        bd_in = 1'b1;
        vpc = 32'h0000_3024;
        push("bd_req", 32'd1);            chk_req();
        tick();
        idle();
        push("bd_epc", 32'h0000_3020);    rd(5'd14);
        push("bd_cause", cause_of(1'b1, 6'd0, 5'd12)); rd(5'd13);

        // EXL blocks every new request until eret.
        mtc0(5'd12, 32'h0000_FC03);
        exc_code_in = 5'd10;
        hw_int = 6'h3F;
        vpc = 32'h0000_4000;
        push("exl_block", 32'd0);         chk_req();
        tick();
        push("exl_block_hold", 32'd0);    chk_req();
        eret_m = 1'b1;
        push("exl_block_eret", 32'd0);    chk_req();
        tick();
        eret_m = 1'b0;
        push("reassert", 32'd1);          chk_req();
        tick();
        idle();
        push("reassert_cause", cause_of(1'b0, 6'h3F, 5'd0)); rd(5'd13);
        push("reassert_epc", 32'h0000_4000); rd(5'd14);

        // Interrupt beats AdEL, and req discards the mtc0 to EPC.
        eret_m = 1'b1;
        tick();
        idle();
        hw_int = 6'b000001;
        exc_code_in = 5'd4;
        we = 1'b1;
        cp0_addr = 5'd14;
        cp0_wdata = 32'h0000_5000;
        vpc = 32'h0000_4100;
`ifdef CP0_BADVADDR_EN
        bad_addr = 32'h0000_7777;
`endif
        push("prio_req", 32'd1);          chk_req();
        tick();
        idle();
        push("prio_epc", 32'h0000_4100);  rd(5'd14);
        push("prio_cause", cause_of(1'b0, 6'b000001, 5'd0)); rd(5'd13);
        push("prio_badvaddr", 32'd0);     rd(5'd8);

        // Reset the cycle after a request.
        eret_m = 1'b1;
        tick();
        idle();
        exc_code_in = 5'd12;
        vpc = 32'h0000_5000;
        push("pre_reset_req", 32'd1);     chk_req();
        tick();
        reset = 1'b1;
        push("req_reset_hi", 32'd0);      chk_req();
        tick();
        reset = 1'b0;
        idle();
        push("post_reset_sr", 32'd0);     rd(5'd12);
        push("post_reset_cause", 32'd0);  rd(5'd13);
        push("post_reset_epc", 32'd0);    rd(5'd14);

        // mtc0 corner cases: eret with SR write, Cause read-only, EPC low bits.
        we = 1'b1;
        cp0_addr = 5'd12;
        cp0_wdata = 32'h0000_0C03;
        eret_m = 1'b1;
        tick();
        idle();
        push("eret_wins_sr", 32'h0000_0C01); rd(5'd12);
        mtc0(5'd13, 32'hFFFF_FFFF);
        push("cause_ro", 32'd0);          rd(5'd13);
        mtc0(5'd14, 32'h0000_1237);
        push("epc_align", 32'h0000_1234); rd(5'd14);
        exc_code_in = 5'd8;
        eret_m = 1'b1;
        vpc = 32'h0000_6000;
        push("req_beats_eret", 32'd1);    chk_req();
        tick();
        idle();
        push("req_beats_eret_sr", 32'h0000_0C03); rd(5'd12);

        // AdEL latches BadVAddr when the option is built in; addr 8 stays 0 otherwise.
        eret_m = 1'b1;
        tick();
        idle();
        exc_code_in = 5'd4;
        vpc = 32'h0000_3000;
`ifdef CP0_BadVADDR_UNUSED
`endif
`ifdef CP0_BADVADDR_EN
        bad_addr = 32'h0000_3001;
`endif
        tick();
        idle();
`ifdef CP0_BADVADDR_EN
        push("badvaddr_adel", 32'h0000_3001);
`else
        push("addr8_zero", 32'd0);
`endif
        rd(5'd8);
        push("adel_cause", cause_of(1'b0, 6'd0, 5'd4)); rd(5'd13);

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: observed %0d pending required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_exc_ctrl.md
Name: cp0_exc_ctrl

Overview:
Coprocessor-0 exception/interrupt controller for the 5-stage MIPS pipeline. It sits beside the M stage and takes the M-stage victim PC, branch-delay flag and pipelined exception code. It produces Req, the global flush/redirect that forces every pipeline register to its bubble/handler state, and holds SR, Cause, EPC and PRId for mfc0, mtc0 and eret.

Parameters:
PRID_VAL, 32'h2023_0007, read-only value returned for register 15
HANDLER_PC, 32'h0000_4180, exception entry address, driven on handler_pc

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
we  in  1  mtc0 write enable, M stage
cp0_addr  in  5  mtc0/mfc0 register number (rd field)
cp0_wdata  in  32  mtc0 write data
cp0_rdata  out  32  mfc0 read data, combinational
vpc  in  32  M-stage instruction PC (victim PC)
bd_in  in  1  M-stage instruction sits in a branch delay slot
exc_code_in  in  5  M-stage pipelined ExcCode; 0 = none
eret_m  in  1  eret is in the M stage
hw_int  in  6  external interrupt lines, level-sensitive
req  out  1  take exception/interrupt this cycle (flush all stages)
epc_out  out  32  current EPC, used as the eret target
handler_pc  out  32  constant HANDLER_PC

Behaviour:
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; other bits read 0.
  - Cause (13): BD[31], IP[15:10], ExcCode[6:2]; other bits read 0. Cause is read-only to mtc0.
  - EPC (14): 32 bits, bits [1:0] forced 0.
  - PRId (15): PRID_VAL.
- Reset: SR=0, Cause=0, EPC=0. req=0 while reset is high. epc_out=0, cp0_rdata=0 for unmapped addresses.
- Request logic, all combinational, same cycle:
  - int_pend = |(hw_int & SR.IM) & SR.IE & ~SR.EXL
  - exc_pend = (exc_code_in != 0) & ~SR.EXL
  - req = (int_pend | exc_pend) & ~reset
- Priority: interrupt over exception. On a req cycle, at the clock edge:
  - EXL <= 1.
  - ExcCode <= int_pend ? 0 : exc_code_in.
  - BD <= bd_in.
  - EPC <= (bd_in ? vpc-4 : vpc) & ~3.
- Cause.IP <= hw_int on every non-reset cycle, regardless of req/EXL.
- eret_m (no req): EXL <= 0 at the edge. epc_out = EPC register; mtc0→eret forwarding is handled externally by the stall unit.
- mtc0 (we=1, no req): writes SR's IM/EXL/IE fields or EPC (bits [1:0] dropped). Writes to Cause, PRId or other addresses are ignored.
- Simultaneous events:
  - req beats we and eret_m: the M instruction is the victim, so its mtc0/eret has no effect.
  - we to SR with eret_m in the same cycle: eret's EXL clear wins; IM/IE are taken from cp0_wdata.
- While EXL=1, no new req is generated, even with a nonzero exc_code_in or an enabled interrupt line.
- cp0_rdata is combinational from current register values (pre-write), mapped per the register list above.
- Latency: req is asserted in the same cycle the cause appears at M. Pipeline registers load HANDLER_PC / bubbles on the following edge.

Optional Feature:
Macro CP0_BADVADDR_EN.
- Defined:
  - Adds input bad_addr[31:0] and register BadVAddr (8), reset 0, readable via mfc0 addr 8.
  - Latched from bad_addr on a req edge when exception-taken (not interrupt) and exc_code_in is 4 (AdEL) or 5 (AdES).
  - Not writable by mtc0.
- Undefined: no bad_addr port; addr 8 reads 0.

Test Plan:
- Reset then SR=32'h0000_FC01 via mtc0 → cp0_rdata(12)=32'h0000_FC01. Assert hw_int=6'b000100 → req=1 same cycle. Next cycle: Cause=32'h0000_1000, SR.EXL=1, EPC=vpc.
- SR.IE=0, exc_code_in=5'd12 (Ov), vpc=32'h0000_3010, bd_in=0 → req=1. Then EPC=32'h0000_3010, Cause[6:2]=12, BD=0.
- Same exception with bd_in=1, vpc=32'h0000_3024 → EPC=32'h0000_3020, Cause[31]=1.
- With EXL=1, exc_code_in=5'd10 and hw_int=6'h3F with all IM set → req stays 0. Then eret_m=1 → EXL=0 next cycle, and req reasserts if the cause persists.
- Interrupt and exc_code_in=4 in the same cycle with we=1 to EPC (wdata 32'h0000_5000) → ExcCode=0, EPC=vpc not 32'h0000_5000.
- Reset asserted the cycle after req → all registers 0, req=0. With CP0_BADVADDR_EN: AdEL, bad_addr=32'h0000_3001 → cp0_rdata(8)=32'h0000_3001.
